// File: rtl/isp_raw_tpg_pkg.sv
// -----------------------------------------------------------------------------
// isp_raw_tpg_pkg
// Shared definitions for the raw Bayer test-pattern generator:
//   - FSM state encoding and pattern codes
//   - colour-bar table (left to right) and per-channel selection helper
//   - LFSR seed and tap mask used by the optional noise path
// -----------------------------------------------------------------------------
package isp_raw_tpg_pkg;

  localparam int CW = 16;  // counter / coordinate width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VS   = 3'd1,
    ST_VBP  = 3'd2,
    ST_ACT  = 3'd3,
    ST_VFP  = 3'd4
  } tpg_state_e;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_SOLID   = 2'd2,
    PAT_CHECKER = 2'd3
  } tpg_pattern_e;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bar colour as {r,g,b}; bar 0 is leftmost.
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    logic [2:0] rgb;
    case (bar)
      3'd0:    rgb = 3'b111;  // white
      3'd1:    rgb = 3'b110;  // yellow
      3'd2:    rgb = 3'b011;  // cyan
      3'd3:    rgb = 3'b010;  // green
      3'd4:    rgb = 3'b101;  // magenta
      3'd5:    rgb = 3'b100;  // red
      3'd6:    rgb = 3'b001;  // blue
      default: rgb = 3'b000;  // black
    endcase
    return rgb;
  endfunction

  // Bayer channel index: 0 B, 1/2 G, 3 R
  function automatic logic chan_bit(input logic [2:0] rgb, input logic [1:0] idx);
    logic b;
    case (idx)
      2'd0:    b = rgb[0];
      2'd3:    b = rgb[2];
      default: b = rgb[1];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/isp_raw_tpg_pattern.sv
// -----------------------------------------------------------------------------
// isp_raw_tpg_pattern
// Combinational pixel generator: maps active coordinates, Bayer channel index
// and the latched pattern settings to one raw pixel value.
// Ports:
//   x_i, y_i       active pixel coordinates
//   idx_i          Bayer channel index (0 B, 1/2 G, 3 R)
//   pattern_i      pattern select
//   solid_*_i      solid levels, upper BITS bits used
//   pix_o          raw pixel
// -----------------------------------------------------------------------------
module isp_raw_tpg_pattern
  import isp_raw_tpg_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int WIDTH = 1280
) (
  input  logic [CW-1:0]   x_i,
  input  logic [CW-1:0]   y_i,
  input  logic [1:0]      idx_i,
  input  tpg_pattern_e    pattern_i,
  input  logic [7:0]      solid_r_i,
  input  logic [7:0]      solid_g_i,
  input  logic [7:0]      solid_b_i,
  output logic [BITS-1:0] pix_o
);

  localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
  localparam logic [CW-1:0] BAR_W_C = CW'(BAR_W);
  localparam logic [BITS-1:0] MAXV = {BITS{1'b1}};

  logic [CW-1:0] bar_full;
  logic [2:0]    bar;
  logic [7:0]    solid_lvl;
  logic          unused_y;

  assign bar_full = x_i / BAR_W_C;
  // Leftover pixels when WIDTH is not a multiple of 8 fall into the black bar.
  assign bar      = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];
  assign unused_y = ^{y_i[CW-1:7], y_i[5:1]};

  always_comb begin
    case (idx_i)
      2'd0:    solid_lvl = solid_b_i;
      2'd3:    solid_lvl = solid_r_i;
      default: solid_lvl = solid_g_i;
    endcase
  end

  always_comb begin
    pix_o = '0;
    case (pattern_i)
      PAT_BARS:    pix_o = chan_bit(bar_rgb(bar), idx_i) ? MAXV : '0;
      PAT_RAMP:    pix_o = BITS'(x_i);
      PAT_SOLID:   pix_o = BITS'(solid_lvl >> (8 - BITS));
      PAT_CHECKER: pix_o = (x_i[6] ^ y_i[6]) ? MAXV : '0;
      default:     pix_o = '0;
    endcase
  end

endmodule

// File: rtl/isp_raw_tpg.sv
// -----------------------------------------------------------------------------
// isp_raw_tpg
// Raw Bayer test-pattern / timing generator standing in for the sensor.
// Produces full frames: VS (vsync lines) -> VBP -> ACT -> VFP, each line being
// WIDTH active clocks plus HBLANK blank clocks.
// Optional feature macro: ISP_TPG_NOISE_EN adds LFSR noise to active pixels;
// without it noise_lvl is ignored and out_raw is the pure pattern.
// Ports:
//   pclk, rst_n         pixel clock, async active-low reset
//   enable              run request, honoured at frame boundaries
//   pattern             0 bars, 1 ramp, 2 solid, 3 checker
//   solid_r/g/b         solid levels
//   noise_lvl           noise amplitude (noise build only)
//   out_href/out_vsync  timing strobes
//   out_raw             pixel, 0 outside href
//   frame_done          pulse on last clock of a frame
//   frame_cnt           completed frame count (wraps)
// Assumes VSYNC_LINES >= 1 and HEIGHT >= 1; VBACK/VFRONT may be 0.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | stopped, waiting for enable
// ST_VS    | vsync lines, out_vsync high
// ST_VBP   | back-porch blank lines
// ST_ACT   | active lines, href for hcnt < WIDTH
// ST_VFP   | front-porch blank lines, frame ends on last clock
// -----------------------------------------------------------------------------
module isp_raw_tpg
  import isp_raw_tpg_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int BAYER       = 0,
  parameter int HBLANK      = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBACK       = 8,
  parameter int VFRONT      = 8
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      pattern,
  input  logic [7:0]      solid_r,
  input  logic [7:0]      solid_g,
  input  logic [7:0]      solid_b,
  input  logic [2:0]      noise_lvl,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            frame_done,
  output logic [15:0]     frame_cnt
);

  localparam logic [CW-1:0] LINE_LAST = CW'(WIDTH + HBLANK - 1);
  localparam logic [CW-1:0] WIDTH_C   = CW'(WIDTH);
  localparam logic [1:0]    BAYER_C   = 2'(BAYER);

  tpg_state_e     state_q, state_d;
  logic [CW-1:0]  hcnt_q, hcnt_d;
  logic [CW-1:0]  vcnt_q, vcnt_d;
  logic           href_q, vsync_q;
  logic [BITS-1:0] raw_q;
  logic [15:0]    fcnt_q;
  tpg_pattern_e   pat_q;
  logic [7:0]     sr_q, sg_q, sb_q;

  logic           line_end, last_line, frame_end, active, vs_entry;
  logic [CW-1:0]  state_lines;
  logic [1:0]     idx;
  logic [BITS-1:0] pix_pat, pix_out;

  always_comb begin
    case (state_q)
      ST_VS:   state_lines = CW'(VSYNC_LINES);
      ST_VBP:  state_lines = CW'(VBACK);
      ST_ACT:  state_lines = CW'(HEIGHT);
      ST_VFP:  state_lines = CW'(VFRONT);
      default: state_lines = CW'(1);
    endcase
  end

  assign line_end  = (hcnt_q == LINE_LAST);
  assign last_line = (vcnt_q == state_lines - CW'(1));
  // With no front porch the frame ends on the last active line.
  assign frame_end = line_end && last_line &&
                     ((state_q == ST_VFP) || ((VFRONT == 0) && (state_q == ST_ACT)));
  assign active    = (state_q == ST_ACT) && (hcnt_q < WIDTH_C);
  assign vs_entry  = (state_d == ST_VS) && (state_q != ST_VS);
  assign idx       = {vcnt_q[0], hcnt_q[0]} ^ BAYER_C;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (state_q == ST_IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (enable) state_d = ST_VS;
    end else if (!line_end) begin
      hcnt_d = hcnt_q + CW'(1);
    end else begin
      hcnt_d = '0;
      if (!last_line) begin
        vcnt_d = vcnt_q + CW'(1);
      end else begin
        vcnt_d = '0;
        case (state_q)
          ST_VS:   state_d = (VBACK == 0) ? ST_ACT : ST_VBP;
          ST_VBP:  state_d = ST_ACT;
          ST_ACT: begin
            if (VFRONT == 0) state_d = enable ? ST_VS : ST_IDLE;
            else             state_d = ST_VFP;
          end
          ST_VFP:  state_d = enable ? ST_VS : ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  isp_raw_tpg_pattern #(
    .BITS  (BITS),
    .WIDTH (WIDTH)
  ) u_pattern (
    .x_i       (hcnt_q),
    .y_i       (vcnt_q),
    .idx_i     (idx),
    .pattern_i (pat_q),
    .solid_r_i (sr_q),
    .solid_g_i (sg_q),
    .solid_b_i (sb_q),
    .pix_o     (pix_pat)
  );

`ifdef ISP_TPG_NOISE_EN
  logic [15:0]        lfsr_q;
  logic [2:0]         nl_q;
  logic signed [4:0]  ofs_raw, ofs;
  logic signed [BITS+5:0] sum;

  always_comb begin
    ofs_raw = $signed({1'b0, lfsr_q[3:0]}) - 5'sd8;
    ofs     = (nl_q == 3'd0) ? 5'sd0 : (ofs_raw >>> (3'd7 - nl_q));
    sum     = $signed({6'b0, pix_pat}) + (BITS+6)'(ofs);
    if (sum < 0)
      pix_out = '0;
    else if (sum > $signed({6'b0, {BITS{1'b1}}}))
      pix_out = {BITS{1'b1}};
    else
      pix_out = sum[BITS-1:0];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      nl_q   <= '0;
    end else begin
      if (active)   lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      if (vs_entry) nl_q   <= noise_lvl;
    end
  end
`else
  logic unused_noise;
  assign unused_noise = ^noise_lvl;
  assign pix_out      = pix_pat;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      raw_q   <= '0;
      fcnt_q  <= '0;
      pat_q   <= PAT_BARS;
      sr_q    <= '0;
      sg_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      href_q  <= active;
      vsync_q <= (state_d == ST_VS);
      raw_q   <= active ? pix_out : '0;
      if (frame_end) fcnt_q <= fcnt_q + 16'd1;
      // Settings are frozen for the whole frame.
      if (vs_entry) begin
        pat_q <= tpg_pattern_e'(pattern);
        sr_q  <= solid_r;
        sg_q  <= solid_g;
        sb_q  <= solid_b;
      end
    end
  end

  assign out_href   = href_q;
  assign out_vsync  = vsync_q;
  assign out_raw    = raw_q;
  assign frame_done = frame_end;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_isp_raw_tpg.sv
// -----------------------------------------------------------------------------
// tb_isp_raw_tpg
// Directed bench for isp_raw_tpg with a small frame (16x8, 240 clocks/frame).
// Two instances share stimulus: BAYER=0 (u_dut) and BAYER=3 (u_dut3).
// -----------------------------------------------------------------------------
module tb_isp_raw_tpg;

  localparam int FRAME = 240;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] pattern;
  logic [7:0] solid_r, solid_g, solid_b;
  logic [2:0] noise_lvl;

  logic       href0, vsync0, fdone0;
  logic [7:0] raw0;
  logic [15:0] fcnt0;
  logic       href3, vsync3, fdone3;
  logic [7:0] raw3;
  logic [15:0] fcnt3;

  int n_checks = 0;
  int n_errors = 0;

  bit         vs_a [FRAME];
  bit         hr_a [FRAME];
  bit         fd_a [FRAME];
  logic [7:0] r0_a [FRAME];
  logic [7:0] r3_a [FRAME];
  logic [15:0] fc_first;

  always #5 pclk = ~pclk;

  isp_raw_tpg #(
    .BITS(8), .WIDTH(16), .HEIGHT(8), .BAYER(0),
    .HBLANK(4), .VSYNC_LINES(1), .VBACK(2), .VFRONT(1)
  ) u_dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .noise_lvl(noise_lvl), .out_href(href0), .out_vsync(vsync0),
    .out_raw(raw0), .frame_done(fdone0), .frame_cnt(fcnt0)
  );

  isp_raw_tpg #(
    .BITS(8), .WIDTH(16), .HEIGHT(8), .BAYER(3),
    .HBLANK(4), .VSYNC_LINES(1), .VBACK(2), .VFRONT(1)
  ) u_dut3 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .noise_lvl(noise_lvl), .out_href(href3), .out_vsync(vsync3),
    .out_raw(raw3), .frame_done(fdone3), .frame_cnt(fcnt3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples FRAME consecutive negedges; optionally changes pattern/enable
  // right after sample chg_idx.
  task automatic capture_frame(input int chg_idx, input logic [1:0] new_pat,
                               input logic new_en);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge pclk);
      if (i == 0) fc_first = fcnt0;
      vs_a[i] = vsync0;
      hr_a[i] = href0;
      fd_a[i] = fdone0;
      r0_a[i] = raw0;
      r3_a[i] = raw3;
      if (i == chg_idx) begin
        pattern = new_pat;
        enable  = new_en;
      end
    end
  endtask

  // Expected timing: vsync idx 0..19, href one clock after each active
  // counter position (ACT starts at idx 60), frame_done at idx 239.
  task automatic check_timing(input string tag, input bit running);
    int vs_bad, hr_bad, fd_bad, hr_cnt;
    bit e_vs, e_hr, e_fd;
    vs_bad = 0; hr_bad = 0; fd_bad = 0; hr_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      e_vs = running && (i < 20);
      e_hr = running && (i >= 61) && (i < 221) && (((i - 61) % 20) < 16);
      e_fd = running && (i == FRAME - 1);
      if (vs_a[i] != e_vs) vs_bad++;
      if (hr_a[i] != e_hr) hr_bad++;
      if (fd_a[i] != e_fd) fd_bad++;
      if (hr_a[i]) hr_cnt++;
    end
    check({tag, "_vsync_bad"}, vs_bad, 0);
    check({tag, "_href_bad"},  hr_bad, 0);
    check({tag, "_fdone_bad"}, fd_bad, 0);
    check({tag, "_href_cnt"},  hr_cnt, running ? 128 : 0);
  endtask

  function automatic int pix_at(input int row, input int x);
    return 61 + 20 * row + x;
  endfunction

  initial begin
    int bad;
    rst_n = 1'b0; enable = 1'b0; pattern = 2'd1;
    solid_r = 8'hC0; solid_g = 8'h80; solid_b = 8'h40; noise_lvl = 3'd0;
    repeat (3) @(negedge pclk);
    check("rst_href",  href0,  0);
    check("rst_vsync", vsync0, 0);
    check("rst_raw",   raw0,   0);
    check("rst_fdone", fdone0, 0);
    check("rst_fcnt",  fcnt0,  0);

    // idle after reset release without enable
    rst_n = 1'b1;
    repeat (5) @(negedge pclk);
    check("idle_vsync", vsync0, 0);

    // frame 1: ramp
    enable = 1'b1;
    capture_frame(-1, 2'd1, 1'b1);
    check("f1_fcnt_start", fc_first, 0);
    check_timing("f1", 1'b1);
    bad = 0;
    for (int x = 0; x < 16; x++) if (r0_a[pix_at(0, x)] !== 8'(x)) bad++;
    check("f1_ramp_row0_bad", bad, 0);
    bad = 0;
    for (int x = 0; x < 16; x++) if (r3_a[pix_at(5, x)] !== 8'(x)) bad++;
    check("f1_ramp_row5_b3_bad", bad, 0);
    check("f1_raw_blank", r0_a[pix_at(0, 17)], 0);

    // frame 2: still ramp; switch to solid mid-frame
    capture_frame(100, 2'd2, 1'b1);
    check("f2_fcnt_start", fc_first, 1);
    check_timing("f2", 1'b1);
    check("f2_ramp_late_row", r0_a[pix_at(7, 9)], 9);

    // frame 3: solid; switch to bars mid-frame
    capture_frame(100, 2'd0, 1'b1);
    check("f3_fcnt_start", fc_first, 2);
    check_timing("f3", 1'b1);
    bad = 0;
    for (int x = 0; x < 16; x++) begin
      if (r3_a[pix_at(0, x)] !== ((x % 2 == 0) ? 8'hC0 : 8'h80)) bad++;
      if (r3_a[pix_at(1, x)] !== ((x % 2 == 0) ? 8'h80 : 8'h40)) bad++;
    end
    check("f3_solid_b3_bad", bad, 0);
    check("f3_solid_b0_r0x0_B", r0_a[pix_at(0, 0)], 8'h40);
    check("f3_solid_b0_r1x1_R", r0_a[pix_at(1, 1)], 8'hC0);

    // frame 4: bars; drop enable mid-frame
    capture_frame(100, 2'd0, 1'b0);
    check("f4_fcnt_start", fc_first, 3);
    check_timing("f4", 1'b1);
    check("bar_r0x0",     r0_a[pix_at(0, 0)],  8'hFF);
    check("bar_r1x1",     r0_a[pix_at(1, 1)],  8'hFF);
    check("bar_b3_r0x0",  r3_a[pix_at(0, 0)],  8'hFF);
    check("bar_r0x14",    r0_a[pix_at(0, 14)], 8'h00);
    check("bar_r1x15",    r0_a[pix_at(1, 15)], 8'h00);
    check("bar_red_r1x11_R", r0_a[pix_at(1, 11)], 8'hFF);
    check("bar_red_r0x10_B", r0_a[pix_at(0, 10)], 8'h00);
    check("bar_red_r1x10_G", r0_a[pix_at(1, 10)], 8'h00);
    check("bar_yel_r0x2_B",  r0_a[pix_at(0, 2)],  8'h00);
    check("bar_yel_r0x3_G",  r0_a[pix_at(0, 3)],  8'hFF);

    // stopped: nothing for a full frame period, count frozen
    capture_frame(-1, 2'd1, 1'b0);
    check("stop_fcnt_start", fc_first, 4);
    check_timing("stop", 1'b0);
    check("stop_fcnt_end", fcnt0, 4);

    // reset in the middle of an active line
    pattern = 2'd1;
    enable  = 1'b1;
    repeat (106) @(negedge pclk);
    check("pre_rst_href", href0, 1);
    check("pre_rst_raw",  raw0,  4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_href",  href0,  0);
    check("mid_rst_raw",   raw0,   0);
    check("mid_rst_vsync", vsync0, 0);
    check("mid_rst_fcnt",  fcnt0,  0);
    @(negedge pclk);
    rst_n = 1'b1;
    capture_frame(100, 2'd1, 1'b0);
    check("post_rst_vsync0", vs_a[0], 1);
    check_timing("post_rst", 1'b1);
    @(negedge pclk);
    check("post_rst_fcnt", fcnt0, 1);
    check("post_rst_b3_fcnt", fcnt3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
